sysid_checker: RTL and testbench

- Avalon-MM read master that sequences reads of the system-ID slave at boot or on request, and checks it against build-time expectations.
- The slave exposes a 1-bit word address: word 0 holds the system ID and word 1 holds the build timestamp.
- The block captures both words, compares them with its parameters, and reports pass, mismatch or timeout to the host/status logic.
- It sits between the reset controller and the status LEDs/host CSR, and owns the ID slave's read port.

---
 rtl/sysid_checker.sv | 177 +++++++++++++++++
 tb/tb_sysid_checker.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_checker.sv
// sysid_checker
// Avalon-MM read master that reads the two-word system-ID slave (word 0 =
// system ID, word 1 = build timestamp) at boot or on request. It compares both
// words with build-time expectations and reports pass, mismatch or timeout.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   start                 one-cycle check request, dropped while busy
//   avm_address/avm_read  read request to the ID slave
//   avm_waitrequest       slave stall
//   avm_readdata          slave read data
//   busy                  a check is in progress
//   done                  one-cycle pulse at the end of every check
//   id_ok, ts_ok          captured words match expectations (held)
//   timeout_err           all retries timed out (held)
//   id_value, ts_value    captured word 0 / word 1
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h471C9C63,
    parameter logic [31:0] EXPECTED_TS    = 32'h4F3000A6,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 2,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        LAT_ID,
        REQ_TS,
        LAT_TS,
        CHECK,
        RETRY
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] TMO_MAX  = 16'(TIMEOUT_CYCLES);
    localparam logic [1:0]  LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
    localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRIES);

    state_t      state;
    logic [15:0] tmo_cnt;
    logic [2:0]  retry_cnt;
    logic [1:0]  lat_cnt;
    logic        auto_pend;
    logic        capture_now;
    logic        word_sel;

    // Decide whether readdata is to be captured in this cycle. With zero read
    // latency the data arrives in the acceptance cycle itself, so the REQ state
    // captures directly and the LAT state is never visited. Otherwise the LAT
    // state captures once it has waited READ_LATENCY cycles. word_sel tells
    // which of the two words the current read belongs to.
    always_comb begin
        capture_now = 1'b0;
        word_sel    = (state == REQ_TS) || (state == LAT_TS);
        if ((state == REQ_ID || state == REQ_TS) && !avm_waitrequest && READ_LATENCY == 0)
            capture_now = 1'b1;
        if ((state == LAT_ID || state == LAT_TS) && lat_cnt == LAT_LAST)
            capture_now = 1'b1;
    end

    // Main sequencer. All outputs are registered here so the bus strobe and the
    // status flags change only on clock edges. Reset drops the read strobe at
    // once and aborts any read in flight without a done pulse. done defaults
    // low every cycle, so every assignment to it is a single-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tmo_cnt     <= 16'd0;
            retry_cnt   <= 3'd0;
            lat_cnt     <= 2'd0;
            auto_pend   <= AUTO_START;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            done <= 1'b0;
            if (capture_now) begin
                if (!word_sel) begin
                    id_value    <= avm_readdata;
                    tmo_cnt     <= 16'd0;
                    avm_read    <= 1'b1;
                    avm_address <= 1'b1;
                    state       <= REQ_TS;
                end else begin
                    ts_value <= avm_readdata;
                    avm_read <= 1'b0;
                    done     <= 1'b1;
                    state    <= CHECK;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start || auto_pend) begin
                            auto_pend   <= 1'b0;
                            busy        <= 1'b1;
                            id_ok       <= 1'b0;
                            ts_ok       <= 1'b0;
                            timeout_err <= 1'b0;
                            retry_cnt   <= 3'd0;
                            tmo_cnt     <= 16'd0;
                            avm_read    <= 1'b1;
                            avm_address <= 1'b0;
                            state       <= REQ_ID;
                        end
                    end
                    REQ_ID, REQ_TS: begin
                        if (!avm_waitrequest) begin
                            avm_read <= 1'b0;
                            lat_cnt  <= 2'd0;
                            state    <= (state == REQ_ID) ? LAT_ID : LAT_TS;
                        end else if (tmo_cnt == TMO_LAST) begin
                            avm_read <= 1'b0;
                            tmo_cnt  <= TMO_MAX;
                            state    <= RETRY;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    LAT_ID, LAT_TS: begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                    CHECK: begin
                        id_ok <= (id_value == EXPECTED_ID);
                        ts_ok <= (ts_value == EXPECTED_TS);
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    RETRY: begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt   <= retry_cnt + 3'd1;
                            tmo_cnt     <= 16'd0;
                            avm_read    <= 1'b1;
                            avm_address <= 1'b0;
                            state       <= REQ_ID;
                        end else begin
                            timeout_err <= 1'b1;
                            id_ok       <= 1'b0;
                            ts_ok       <= 1'b0;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: begin
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker
// Scoreboard bench for sysid_checker. The main DUT uses READ_LATENCY=2,
// TIMEOUT_CYCLES=4, MAX_RETRIES=2, AUTO_START=1 against a behavioural slave
// with programmable stalls and data. A second zero-latency instance with
// auto-start disabled checks the fastest-path cycle timing.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h471C9C63;
    localparam logic [31:0] EXP_TS = 32'h4F3000A6;
    localparam int LAT = 2;
    localparam int TMO = 4;
    localparam int RETRIES = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address, avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;

    logic        z_start = 1'b0;
    logic        z_address, z_read, z_busy, z_done, z_id_ok, z_ts_ok, z_tmo;
    logic [31:0] z_readdata, z_id_value, z_ts_value;

    int cyc = 0;
    int checks_total = 0;
    int checks_passed = 0;

    // Slave behaviour: per-word stall length and data, counters per check.
    logic [31:0] word_d [2];
    int          wcfg [2];
    int          stall_seen = 0;
    int          rc0 = 0, rc1 = 0, acc_cnt = 0;
    int          dq_cyc [$];
    logic [31:0] dq_dat [$];
    logic        prev_stalled = 1'b0;
    logic        prev_addr = 1'b0;

    // Reference model state: last captured words, survive a timeout.
    logic [31:0] last_id = 32'd0, last_ts = 32'd0;

    typedef struct {
        bit          chk_cycle;
        int          done_cyc;
        bit          e_id_ok, e_ts_ok, e_tmo;
        logic [31:0] e_id, e_ts;
        int          e_rc0, e_rc1, e_acc;
    } exp_t;
    exp_t expq [$];

    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(LAT),
        .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(RETRIES), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
        .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value)
    );

    sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0),
        .TIMEOUT_CYCLES(255), .MAX_RETRIES(2), .AUTO_START(1'b0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .start(z_start),
        .avm_address(z_address), .avm_read(z_read),
        .avm_waitrequest(1'b0), .avm_readdata(z_readdata),
        .busy(z_busy), .done(z_done), .id_ok(z_id_ok), .ts_ok(z_ts_ok),
        .timeout_err(z_tmo), .id_value(z_id_value), .ts_value(z_ts_value)
    );

    // Zero-wait, zero-latency slave for the second instance.
    assign z_readdata = z_address ? EXP_TS : EXP_ID;

    // Free-running clock and cycle label.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural ID slave, driven 1 time unit after each edge. A read stalls
    // for wcfg[address] cycles, then is accepted; its data appears LAT cycles
    // after acceptance and random junk is shown on every other cycle.
    always begin
        @(posedge clk);
        #1;
        if (!reset_n) begin
            avm_waitrequest = 1'b0;
            stall_seen = 0;
            rc0 = 0; rc1 = 0; acc_cnt = 0;
            dq_cyc.delete();
            dq_dat.delete();
            prev_stalled = 1'b0;
            avm_readdata = $urandom;
        end else begin
            if (avm_read) begin
                if (prev_stalled) checkOutput("addr_stable", 32'(avm_address), 32'(prev_addr));
                if (avm_address) rc1++; else rc0++;
                prev_addr = avm_address;
                if (stall_seen < wcfg[avm_address]) begin
                    avm_waitrequest = 1'b1;
                    stall_seen++;
                    prev_stalled = 1'b1;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_seen = 0;
                    prev_stalled = 1'b0;
                    acc_cnt++;
                    dq_cyc.push_back(cyc + LAT);
                    dq_dat.push_back(word_d[avm_address]);
                end
            end else begin
                avm_waitrequest = 1'($urandom_range(0, 1));
                stall_seen = 0;
                prev_stalled = 1'b0;
            end
            if (dq_cyc.size() > 0 && dq_cyc[0] == cyc) begin
                avm_readdata = dq_dat.pop_front();
                void'(dq_cyc.pop_front());
            end else begin
                avm_readdata = $urandom;
            end
        end
    end

    // Monitor: every done pulse pops one expected result, checks timing and
    // bus activity, then checks the held results on the following cycle.
    always begin
        exp_t e;
        @(posedge clk);
        #3;
        if (reset_n && done) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = expq.pop_front();
                if (e.chk_cycle) checkOutput("done_cycle", 32'(cyc), 32'(e.done_cyc));
                checkOutput("read_cycles_addr0", 32'(rc0), 32'(e.e_rc0));
                checkOutput("read_cycles_addr1", 32'(rc1), 32'(e.e_rc1));
                checkOutput("reads_accepted", 32'(acc_cnt), 32'(e.e_acc));
                rc0 = 0; rc1 = 0; acc_cnt = 0;
                @(posedge clk);
                #3;
                checkOutput("id_ok", 32'(id_ok), 32'(e.e_id_ok));
                checkOutput("ts_ok", 32'(ts_ok), 32'(e.e_ts_ok));
                checkOutput("timeout_err", 32'(timeout_err), 32'(e.e_tmo));
                checkOutput("id_value", id_value, e.e_id);
                checkOutput("ts_value", ts_value, e.e_ts);
                checkOutput("busy_after_done", 32'(busy), 32'd0);
                checkOutput("read_after_done", 32'(avm_read), 32'd0);
            end
        end
    end

    // Builds the expected outcome of one check started in cycle n.
    function automatic exp_t modelCheck(input int n, input logic [31:0] d0, input logic [31:0] d1,
                                        input int s0, input int s1);
        exp_t e;
        if (s0 >= TMO) begin
            e.chk_cycle = 1'b0;
            e.done_cyc  = 0;
            e.e_id_ok   = 1'b0;
            e.e_ts_ok   = 1'b0;
            e.e_tmo     = 1'b1;
            e.e_id      = last_id;
            e.e_ts      = last_ts;
            e.e_rc0     = (RETRIES + 1) * TMO;
            e.e_rc1     = 0;
            e.e_acc     = 0;
        end else begin
            e.chk_cycle = 1'b1;
            e.done_cyc  = n + (s0 + 1 + LAT) + (s1 + 1 + LAT) + 1;
            e.e_id_ok   = (d0 == EXP_ID);
            e.e_ts_ok   = (d1 == EXP_TS);
            e.e_tmo     = 1'b0;
            e.e_id      = d0;
            e.e_ts      = d1;
            e.e_rc0     = s0 + 1;
            e.e_rc1     = s1 + 1;
            e.e_acc     = 2;
        end
        return e;
    endfunction

    // Waits, bounded, until the scoreboard is drained and the DUT is idle.
    task automatic waitIdle();
        int k = 0;
        while ((expq.size() != 0 || busy) && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("idle_wait_expired", 32'(k >= 400), 32'd0);
    endtask

    // Programs the slave, pulses start and pushes the expected result.
    // Optionally pulses a second start while busy, which must be dropped.
    task automatic applyStimulus(input logic [31:0] d0, input logic [31:0] d1, input int s0,
                                 input int s1, input bit push, input bit drop_start);
        exp_t e;
        waitIdle();
        word_d[0] = d0; word_d[1] = d1;
        wcfg[0] = s0;   wcfg[1] = s1;
        e = modelCheck(cyc, d0, d1, s0, s1);
        if (push) begin
            expq.push_back(e);
            if (s0 < TMO) begin
                last_id = d0;
                last_ts = d1;
            end
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (drop_start) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    // Releases reset in the current cycle; the auto-start check is expected.
    task automatic releaseReset(input bit with_start);
        word_d[0] = EXP_ID; word_d[1] = EXP_TS;
        wcfg[0] = 0; wcfg[1] = 0;
        start = with_start;
        expq.push_back(modelCheck(cyc, EXP_ID, EXP_TS, 0, 0));
        last_id = EXP_ID;
        last_ts = EXP_TS;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Directed timing of the zero-latency instance: reads on consecutive
    // cycles, done three cycles after start, results one cycle later.
    task automatic checkZeroLatency();
        z_start = 1'b1;
        @(posedge clk); #1;
        z_start = 1'b0;
        checkOutput("z_read_c1", 32'(z_read), 32'd1);
        checkOutput("z_addr_c1", 32'(z_address), 32'd0);
        checkOutput("z_busy_c1", 32'(z_busy), 32'd1);
        @(posedge clk); #1;
        checkOutput("z_read_c2", 32'(z_read), 32'd1);
        checkOutput("z_addr_c2", 32'(z_address), 32'd1);
        @(posedge clk); #1;
        checkOutput("z_done_c3", 32'(z_done), 32'd1);
        checkOutput("z_read_c3", 32'(z_read), 32'd0);
        @(posedge clk); #1;
        checkOutput("z_done_c4", 32'(z_done), 32'd0);
        checkOutput("z_id_ok", 32'(z_id_ok), 32'd1);
        checkOutput("z_ts_ok", 32'(z_ts_ok), 32'd1);
        checkOutput("z_tmo", 32'(z_tmo), 32'd0);
        checkOutput("z_busy_c4", 32'(z_busy), 32'd0);
        checkOutput("z_id_value", z_id_value, EXP_ID);
        checkOutput("z_ts_value", z_ts_value, EXP_TS);
    endtask

    // Checks that every output of the main DUT is at its reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_read"}, 32'(avm_read), 32'd0);
        checkOutput({tag, "_addr"}, 32'(avm_address), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_flags"}, 32'({id_ok, ts_ok, timeout_err}), 32'd0);
        checkOutput({tag, "_id_value"}, id_value, 32'd0);
        checkOutput({tag, "_ts_value"}, ts_value, 32'd0);
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        logic [31:0] d0, d1;
        int r, found;
        word_d[0] = EXP_ID; word_d[1] = EXP_TS;
        wcfg[0] = 0; wcfg[1] = 0;

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        checkOutput("z_reset_busy", 32'({z_busy, z_read, z_done, z_tmo}), 32'd0);

        // Auto-start on release, with a simultaneous start: one check only.
        releaseReset(1'b1);
        $display("[TB] auto-start released at cycle %0d", cyc - 1);
        checkZeroLatency();
        waitIdle();
        repeat (20) @(posedge clk);
        #1;

        // Passing check, then a timestamp mismatch (no retry).
        applyStimulus(EXP_ID, EXP_TS, 0, 0, 1'b1, 1'b0);
        applyStimulus(EXP_ID, 32'h4F3000A7, 0, 0, 1'b1, 1'b0);

        // Slave that never answers: three attempts, then timeout_err.
        applyStimulus(EXP_ID, EXP_TS, 1000, 1000, 1'b1, 1'b1);

        // Stalled timestamp read with latency, and a dropped start.
        applyStimulus(EXP_ID, EXP_TS, 0, 3, 1'b1, 1'b1);

        // Randomized data and stall patterns below the timeout.
        for (int i = 0; i < 12; i++) begin
            r  = $urandom_range(0, 3);
            d0 = (r == 0) ? $urandom : EXP_ID;
            r  = $urandom_range(0, 3);
            d1 = (r == 0) ? EXP_TS + 32'd1 : (r == 1) ? $urandom : EXP_TS;
            applyStimulus(d0, d1, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1),
                          1'b1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // Reset during the timestamp read: bus released, no done.
        applyStimulus(EXP_ID, EXP_TS, 0, 3, 1'b0, 1'b0);
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            if (avm_read && avm_address) found = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("reach_req_ts", 32'(found), 32'd1);
        #4;
        reset_n = 1'b0;
        #1;
        checkResetState("midread_reset");
        last_id = 32'd0;
        last_ts = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("held_reset");
        releaseReset(1'b0);
        waitIdle();
        applyStimulus(EXP_ID, EXP_TS, 2, 1, 1'b1, 1'b0);
        waitIdle();
        repeat (10) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
